multicycle_controller: RTL

//  Moore control FSM for the 8-bit multicycle CPU. Sequences the shared datapath:

---
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the 8-bit multicycle CPU datapath.
// Optional ADDI support is enabled by defining MC_ADDI_EN.
module multicycle_controller #(
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       retire
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,  S_FETCH2  = 4'd1,  S_FETCH3 = 4'd2,  S_FETCH4 = 4'd3,
    S_DECODE  = 4'd4,  S_MEMADR  = 4'd5,  S_LBRD   = 4'd6,  S_LBWR   = 4'd7,
    S_SBWR    = 4'd8,  S_RTYPEEX = 4'd9,  S_RTYPEWR = 4'd10, S_BEQEX = 4'd11,
    S_JEX     = 4'd12, S_ADDIEX  = 4'd13, S_ADDIWR = 4'd14
  } state_t;

  localparam state_t     LAST_FETCH = state_t'(4'(INSTR_BYTES - 1));
  localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000, OP_RTYPE = 6'b000000,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t     r_state, w_next;
  logic       r_run;
  logic       r_memread, r_memwrite, r_iord, r_memtoreg, r_regdst, r_regwrite;
  logic       r_alusrca, r_pcen, r_retire;
  logic [3:0] r_irwrite;
  logic [1:0] r_alusrcb, r_pcsource;
  logic [2:0] r_alucontrol;
  logic       w_memread, w_memwrite, w_iord, w_memtoreg, w_regdst, w_regwrite;
  logic       w_alusrca, w_pcen, w_retire, w_decode_nop;
  logic [3:0] w_irwrite;
  logic [1:0] w_alusrcb, w_pcsource;
  logic [2:0] w_alucontrol;

  always_comb begin
    w_next = S_FETCH1;
    if (r_run) begin
      case (r_state)
        S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4:
          w_next = (r_state == LAST_FETCH) ? S_DECODE : state_t'(r_state + 4'd1);
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_RTYPEEX;
            OP_BEQ:       w_next = S_BEQEX;
            OP_J:         w_next = S_JEX;
`ifdef MC_ADDI_EN
            OP_ADDI:      w_next = S_ADDIEX;
`endif
            default:      w_next = S_FETCH1;
          endcase
        end
        S_MEMADR:  w_next = (op == OP_SB) ? S_SBWR : S_LBRD;
        S_LBRD:    w_next = S_LBWR;
        S_RTYPEEX: w_next = S_RTYPEWR;
        S_ADDIEX:  w_next = S_ADDIWR;
        default:   w_next = S_FETCH1;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_memread = 1'b0; w_memwrite = 1'b0; w_irwrite = '0; w_iord = 1'b0;
    w_memtoreg = 1'b0; w_regdst = 1'b0; w_regwrite = 1'b0; w_alusrca = 1'b0;
    w_alusrcb = '0; w_pcsource = '0; w_pcen = 1'b0; w_retire = 1'b0;
    w_alucontrol = ALU_ADD;
    case (w_next)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        w_memread = 1'b1;
        w_irwrite = 4'b0001 << w_next[1:0];
        w_alusrcb = 2'b01;
        w_pcen    = 1'b1;
      end
      S_DECODE: w_alusrcb = 2'b11;
      S_MEMADR: begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
      S_LBRD:   begin w_memread = 1'b1; w_iord = 1'b1; end
      S_LBWR:   begin w_regwrite = 1'b1; w_memtoreg = 1'b1; w_retire = 1'b1; end
      S_SBWR:   begin w_memwrite = 1'b1; w_iord = 1'b1; w_retire = 1'b1; end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        case (funct)
          6'b100000: w_alucontrol = ALU_ADD;
          6'b100010: w_alucontrol = ALU_SUB;
          6'b100100: w_alucontrol = ALU_AND;
          6'b100101: w_alucontrol = ALU_OR;
          6'b101010: w_alucontrol = ALU_SLT;
          default:   w_alucontrol = ALU_AND;
        endcase
      end
      S_RTYPEWR: begin w_regdst = 1'b1; w_regwrite = 1'b1; w_retire = 1'b1; end
      S_BEQEX: begin
        w_alusrca = 1'b1; w_alucontrol = ALU_SUB; w_pcsource = 2'b01; w_retire = 1'b1;
      end
      S_JEX:    begin w_pcsource = 2'b10; w_pcen = 1'b1; w_retire = 1'b1; end
      S_ADDIEX: begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
      S_ADDIWR: begin w_regwrite = 1'b1; w_retire = 1'b1; end
      default: ;
    endcase
  end

  // r_run holds the outputs idle until the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH1; r_run <= 1'b0;
      r_memread <= 1'b0; r_memwrite <= 1'b0; r_irwrite <= '0; r_iord <= 1'b0;
      r_memtoreg <= 1'b0; r_regdst <= 1'b0; r_regwrite <= 1'b0; r_alusrca <= 1'b0;
      r_alusrcb <= '0; r_pcsource <= '0; r_pcen <= 1'b0; r_retire <= 1'b0;
      r_alucontrol <= ALU_ADD;
    end else begin
      r_state <= w_next; r_run <= 1'b1;
      r_memread <= w_memread; r_memwrite <= w_memwrite; r_irwrite <= w_irwrite;
      r_iord <= w_iord; r_memtoreg <= w_memtoreg; r_regdst <= w_regdst;
      r_regwrite <= w_regwrite; r_alusrca <= w_alusrca; r_alusrcb <= w_alusrcb;
      r_pcsource <= w_pcsource; r_pcen <= w_pcen; r_retire <= w_retire;
      r_alucontrol <= w_alucontrol;
    end
  end

  // Branch-taken and decode-time NOP depend on inputs valid only in the current state.
  assign w_decode_nop = (r_state == S_DECODE) && (w_next == S_FETCH1);

  assign memread    = r_memread;
  assign memwrite   = r_memwrite;
  assign irwrite    = r_irwrite;
  assign iord       = r_iord;
  assign memtoreg   = r_memtoreg;
  assign regdst     = r_regdst;
  assign regwrite   = r_regwrite;
  assign alusrca    = r_alusrca;
  assign alusrcb    = r_alusrcb;
  assign pcsource   = r_pcsource;
  assign pcen       = r_pcen | ((r_state == S_BEQEX) && zero);
  assign alucontrol = r_alucontrol;
  assign state      = r_state;
  assign retire     = r_retire | w_decode_nop;

endmodule
